pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the core.
//   Carries a control vector and a data payload under a valid/ready handshake.
//   Optional 2-entry skid buffer breaks the combinational ready path from downstream stalls.
//   Synchronous flush inserts a bubble; saturating stall counter supports perf analysis.
// PARAMETERS
//   DATA_W   32  payload width (result, rt, pc, ... concatenated by caller)
//   CTRL_W   8   control width (regwr, memwr, dmen, ...); forced to 0 on flush/reset
//   SKID_EN  1   1: skid buffer, registered up_ready_o; 0: single reg, combinational ready
//   CNT_W    16  width of stall counter
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high reset
//   flush_i      in   1       synchronous wash: discard all held and incoming entries
//   up_valid_i   in   1       upstream entry valid
//   up_ready_o   out  1       stage can accept an entry this cycle
//   up_ctrl_i    in   CTRL_W  upstream control vector
//   up_data_i    in   DATA_W  upstream payload
//   dn_valid_o   out  1       downstream entry valid
//   dn_ready_i   in   1       downstream accepts entry this cycle
//   dn_ctrl_o    out  CTRL_W  control vector; 0 whenever dn_valid_o=0
//   dn_data_o    out  DATA_W  payload; 0 after reset/flush until next load
//   stall_cnt_o  out  CNT_W   count of cycles with dn_valid_o=1 && dn_ready_i=0
// BEHAVIOUR
//   - Transfer in: up_valid_i && up_ready_o; transfer out: dn_valid_o && dn_ready_i.
//   - Latency 1 cycle: accepted entry appears on dn_* the next cycle when stage was empty.
//   - SKID_EN=1 states: EMPTY (no entry), FULL (main reg), SKID (main + skid reg).
//     EMPTY -in-> FULL; FULL -in & !out-> SKID; FULL -out & !in-> EMPTY; FULL -in & out-> FULL;
//     SKID -out-> FULL (skid moves to main; no accept in SKID). up_ready_o = (state!=SKID), registered.
//   - SKID_EN=0: single reg; up_ready_o = !dn_valid_o || dn_ready_i (combinational).
//   - Order preserved: main always older than skid; no entry dropped or duplicated.
//   - flush_i=1: next state EMPTY, ctrl and data of both regs zeroed, input that cycle discarded,
//     up_ready_o=1 the following cycle. Outgoing transfer in flush cycle still counts as delivered.
//   - reset has priority over flush_i; reset values: dn_valid_o=0, dn_ctrl_o=0, dn_data_o=0,
//     up_ready_o=1, stall_cnt_o=0, state EMPTY. Reset mid-stream drops all entries.
//   - stall_cnt_o: +1 per stall cycle, saturates at all-ones, cleared by reset only (not flush).
//   - dn_ctrl_o gated by valid so a bubble can never assert regwr/memwr downstream.
//   - Held outputs stable while dn_valid_o && !dn_ready_i.
// STRUCTURE
//   - Shared package core_pipe_pkg: state encoding (ST_EMPTY/ST_FULL/ST_SKID), default widths.
//   - One sub-module natural: pipe_stage_slot (valid+ctrl+data reg with load/clear); instantiated
//     twice (main, skid) when SKID_EN=1, once otherwise. FSM and counter in top.
// TESTING
//   - Reset: assert reset 2 cycles -> dn_valid_o=0, dn_ctrl_o=0, dn_data_o=0, up_ready_o=1, cnt=0.
//   - Streaming: valid=1, dn_ready=1, data 1..8 -> data 1..8 out in order, 1-cycle latency, no stalls.
//   - Backpressure (SKID_EN=1): dn_ready=0 while sending 0xA,0xB -> state SKID, up_ready_o=0,
//     out holds 0xA; release -> 0xA then 0xB, stall_cnt_o = stalled cycles.
//   - Flush in SKID with up_valid_i=1 data 0xC -> next cycle dn_valid_o=0, ctrl=0, data=0,
//     0xC never emerges, up_ready_o=1.
//   - Reset+flush same cycle mid-stream -> reset values, stall_cnt_o=0.
//   - CNT_W=4, hold dn_ready=0 for 20 cycles -> stall_cnt_o saturates at 4'hF.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
//   Shared definitions for the core's inter-stage pipeline registers.
//   Holds the occupancy state encoding used by pipe_stage_reg and the
//   default payload, control and stall-counter widths.
// ---------------------------------------------------------------------------
package core_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

    // EMPTY: nothing held; FULL: main slot holds an entry;
    // SKID: main slot plus the skid slot both hold entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_slot.sv
// ---------------------------------------------------------------------------
// pipe_stage_slot
//   One storage slot of a pipeline register: a valid bit plus control vector
//   and payload. The owning stage decides when the slot loads, drops or
//   clears.
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, zeroes the slot
//   clear_i  in   synchronous clear (flush), zeroes the slot
//   load_i   in   capture ctrl_i/data_i and mark the slot valid
//   drop_i   in   mark the slot empty, keep ctrl/data as they are
//   ctrl_i   in   control vector to capture
//   data_i   in   payload to capture
//   valid_o  out  slot holds an entry
//   ctrl_o   out  stored control vector (ungated)
//   data_o   out  stored payload
// ---------------------------------------------------------------------------
module pipe_stage_slot
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over load so a flush can never leave a stale entry behind.
    // Dropping only clears valid: the payload keeps showing the last entry
    // that left, which is harmless because control is gated downstream.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (drop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage pipeline register with valid/ready handshake.
//   With SKID_EN=1 a second slot catches the entry that arrives while the
//   downstream stalls, so up_ready_o comes straight from a register and no
//   combinational path runs from dn_ready_i to up_ready_o. With SKID_EN=0 a
//   single slot is used and ready is computed combinationally.
//   flush_i empties the stage and drops the incoming entry; a saturating
//   counter tracks cycles where the output is valid but not taken.
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset (beats flush_i)
//   flush_i      in   discard held and incoming entries
//   up_valid_i   in   upstream entry valid
//   up_ready_o   out  stage accepts an entry this cycle
//   up_ctrl_i    in   upstream control vector
//   up_data_i    in   upstream payload
//   dn_valid_o   out  downstream entry valid
//   dn_ready_i   in   downstream takes the entry this cycle
//   dn_ctrl_o    out  control vector, zero whenever dn_valid_o=0
//   dn_data_o    out  payload
//   stall_cnt_o  out  saturating count of dn_valid_o && !dn_ready_i cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state_q, state_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic              upReady;
    logic              inXfer, outXfer;
    logic              mainLoad, mainDrop, mainFromSkid;
    logic              skidLoad, skidDrop;
    logic              mainValid, skidValid;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainCtrlIn;
    logic [DATA_W-1:0] mainData, skidData, mainDataIn;

    assign inXfer  = up_valid_i && upReady;
    assign outXfer = mainValid && dn_ready_i;

    // When draining the skid slot the main slot refills from it, otherwise
    // it always loads straight from upstream.
    assign mainCtrlIn = mainFromSkid ? skidCtrl : up_ctrl_i;
    assign mainDataIn = mainFromSkid ? skidData : up_data_i;

    pipe_stage_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) uMain (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_i),
        .load_i  (mainLoad),
        .drop_i  (mainDrop),
        .ctrl_i  (mainCtrlIn),
        .data_i  (mainDataIn),
        .valid_o (mainValid),
        .ctrl_o  (mainCtrl),
        .data_o  (mainData)
    );

    generate
        if (SKID_EN) begin : genSkid
            pipe_stage_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) uSkid (
                .clk     (clk),
                .reset   (reset),
                .clear_i (flush_i),
                .load_i  (skidLoad),
                .drop_i  (skidDrop),
                .ctrl_i  (up_ctrl_i),
                .data_i  (up_data_i),
                .valid_o (skidValid),
                .ctrl_o  (skidCtrl),
                .data_o  (skidData)
            );
            // The skid slot is valid exactly while the FSM sits in SKID, so
            // ready is a pure register output here.
            assign upReady = !skidValid;
        end else begin : genSingle
            assign skidValid = 1'b0;
            assign skidCtrl  = '0;
            assign skidData  = '0;
            assign upReady   = !mainValid || dn_ready_i;
        end
    endgenerate

    // Occupancy state register; reset beats flush because the next-state
    // logic only sees flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and slot control. The FULL in-without-out arc is only
    // reachable with the skid slot present, since the single-slot ready
    // stays low while a held entry is stalled.
    always_comb begin
        state_d      = state_q;
        mainLoad     = 1'b0;
        mainDrop     = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidDrop     = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (inXfer) begin
                        mainLoad = 1'b1;
                        state_d  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (inXfer && outXfer) begin
                        mainLoad = 1'b1;
                    end else if (inXfer) begin
                        skidLoad = 1'b1;
                        state_d  = ST_SKID;
                    end else if (outXfer) begin
                        mainDrop = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (outXfer) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        skidDrop     = 1'b1;
                        state_d      = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Stall cycles count up and stick at all-ones; only reset clears them
    // so a flush does not lose performance history.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !dn_ready_i && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign up_ready_o  = upReady;
    assign dn_valid_o  = mainValid;
    assign dn_ctrl_o   = mainValid ? mainCtrl : '0;
    assign dn_data_o   = mainData;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives a skid-buffered stage (dutS) and a single-slot stage (dutN) from
//   the same upstream/downstream inputs. Each is compared every cycle with a
//   small FIFO model of its capacity, and literal expectations pin the
//   skid-buffered instance at key points.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        upValid;
    logic [7:0]  upCtrl;
    logic [31:0] upData;
    logic        dnReady;

    logic        sRdy, sVal, nRdy, nVal;
    logic [7:0]  sCtrl, nCtrl;
    logic [31:0] sData, nData;
    logic [3:0]  sStall, nStall;

    int tests;
    int failed;
    bit checkEn;

    // Model: per instance m (0 = skid, 1 = single), a FIFO of up to 2 entries
    logic [7:0]  mCtrl [2][2];
    logic [31:0] mData [2][2];
    int          mCnt  [2];
    logic [31:0] mLast [2];
    int          mStall[2];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1), .CNT_W(4)) dutS (
        .clk(clk), .reset(reset), .flush_i(flush),
        .up_valid_i(upValid), .up_ready_o(sRdy), .up_ctrl_i(upCtrl), .up_data_i(upData),
        .dn_valid_o(sVal), .dn_ready_i(dnReady), .dn_ctrl_o(sCtrl), .dn_data_o(sData),
        .stall_cnt_o(sStall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b0), .CNT_W(4)) dutN (
        .clk(clk), .reset(reset), .flush_i(flush),
        .up_valid_i(upValid), .up_ready_o(nRdy), .up_ctrl_i(upCtrl), .up_data_i(upData),
        .dn_valid_o(nVal), .dn_ready_i(dnReady), .dn_ctrl_o(nCtrl), .dn_data_o(nData),
        .stall_cnt_o(nStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelReady(input int m);
        if (m == 0) return (mCnt[m] < 2);
        return (mCnt[m] == 0) || dnReady;
    endfunction

    // Advances instance m's model by one clock edge using current inputs.
    task automatic modelStep(input int m);
        bit hasOut, outX, inX;
        hasOut = (mCnt[m] > 0);
        inX    = upValid && modelReady(m);
        outX   = hasOut && dnReady;
        if (reset) begin
            mCnt[m]   = 0;
            mLast[m]  = '0;
            mStall[m] = 0;
        end else begin
            if (hasOut && !dnReady && mStall[m] < 15) mStall[m]++;
            if (flush) begin
                mCnt[m]  = 0;
                mLast[m] = '0;
            end else begin
                if (outX) begin
                    mLast[m]     = mData[m][0];
                    mData[m][0]  = mData[m][1];
                    mCtrl[m][0]  = mCtrl[m][1];
                    mCnt[m]--;
                end
                if (inX) begin
                    mData[m][mCnt[m]] = upData;
                    mCtrl[m][mCnt[m]] = upCtrl;
                    mCnt[m]++;
                end
            end
        end
    endtask

    task automatic compareDut(input int m, input string tag, input logic val,
                              input logic rdy, input logic [7:0] ctrl,
                              input logic [31:0] data, input logic [3:0] stall);
        bit expVal;
        expVal = (mCnt[m] > 0);
        checkOutput({tag, "_valid"}, 32'(val), 32'(expVal));
        checkOutput({tag, "_ready"}, 32'(rdy), 32'(modelReady(m)));
        checkOutput({tag, "_ctrl"}, 32'(ctrl), expVal ? 32'(mCtrl[m][0]) : 32'd0);
        checkOutput({tag, "_data"}, data, expVal ? mData[m][0] : mLast[m]);
        checkOutput({tag, "_stall"}, 32'(stall), 32'(mStall[m]));
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mCnt[m] = 0; mLast[m] = '0; mStall[m] = 0;
            for (int e = 0; e < 2; e++) begin
                mCtrl[m][e] = '0; mData[m][e] = '0;
            end
        end
        forever begin
            @(posedge clk);
            modelStep(0);
            modelStep(1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                compareDut(0, "skid", sVal, sRdy, sCtrl, sData, sStall);
                compareDut(1, "single", nVal, nRdy, nCtrl, nData, nStall);
            end
        end
    end

    // Sets the inputs for the coming cycle just after a rising edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit v,
                                 input logic [7:0] c, input logic [31:0] d,
                                 input bit r);
        @(posedge clk);
        #1;
        reset   = rst;
        flush   = fl;
        upValid = v;
        upCtrl  = c;
        upData  = d;
        dnReady = r;
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        checkEn = 1'b0;
        reset   = 1'b1;
        flush   = 1'b0;
        upValid = 1'b0;
        upCtrl  = '0;
        upData  = '0;
        dnReady = 1'b0;

        // Reset for two cycles
        applyStimulus(1, 0, 0, 8'h00, 32'h0, 0);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("rst_valid", 32'(sVal), 32'd0);
        checkOutput("rst_ctrl", 32'(sCtrl), 32'd0);
        checkOutput("rst_data", sData, 32'd0);
        checkOutput("rst_ready", 32'(sRdy), 32'd1);
        checkOutput("rst_stall", 32'(sStall), 32'd0);
        checkEn = 1'b1;

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 1, 8'h40 + 8'(i), 32'(i), 1);
            @(negedge clk);
            if (i >= 2) checkOutput("stream_data", sData, 32'(i - 1));
        end
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("stream_last", sData, 32'd8);
        checkOutput("stream_last_ctrl", 32'(sCtrl), 32'h48);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("stream_nostall", 32'(sStall), 32'd0);

        // Backpressure: 0xA then 0xB while downstream stalls
        applyStimulus(0, 0, 1, 8'h0A, 32'hA, 0);
        applyStimulus(0, 0, 1, 8'h0B, 32'hB, 0);
        @(negedge clk);
        checkOutput("bp_hold_a", sData, 32'hA);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge clk);
        checkOutput("bp_skid_ready", 32'(sRdy), 32'd0);
        checkOutput("bp_skid_data", sData, 32'hA);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 0);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("bp_release_a", sData, 32'hA);
        checkOutput("bp_stall_cnt", 32'(sStall), 32'd3);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("bp_then_b", sData, 32'hB);
        checkOutput("bp_then_b_ctrl", 32'(sCtrl), 32'h0B);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("bp_drained", 32'(sVal), 32'd0);

        // Flush while in SKID with 0xC arriving
        applyStimulus(0, 0, 1, 8'h0D, 32'hD, 0);
        applyStimulus(0, 0, 1, 8'h0E, 32'hE, 0);
        applyStimulus(0, 1, 1, 8'hCC, 32'hC, 0);
        @(negedge clk);
        checkOutput("fl_pre_ready", 32'(sRdy), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("fl_valid", 32'(sVal), 32'd0);
        checkOutput("fl_ctrl", 32'(sCtrl), 32'd0);
        checkOutput("fl_data", sData, 32'd0);
        checkOutput("fl_ready", 32'(sRdy), 32'd1);
        checkOutput("fl_stall_kept", 32'(sStall), 32'd5);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("fl_no_c", 32'(sVal), 32'd0);

        // Mixed valid/ready patterns
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, (i == 23), (i % 3) != 0, 8'(i * 7), 32'h100 + 32'(i),
                          (i % 5) < 3);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);

        // Reset and flush together mid-stream
        applyStimulus(0, 0, 1, 8'h55, 32'h55, 0);
        applyStimulus(0, 0, 1, 8'h66, 32'h66, 0);
        applyStimulus(1, 1, 1, 8'h77, 32'h77, 0);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("rf_valid", 32'(sVal), 32'd0);
        checkOutput("rf_ctrl", 32'(sCtrl), 32'd0);
        checkOutput("rf_data", sData, 32'd0);
        checkOutput("rf_ready", 32'(sRdy), 32'd1);
        checkOutput("rf_stall", 32'(sStall), 32'd0);

        // Saturation of the 4-bit stall counter
        applyStimulus(0, 0, 1, 8'h99, 32'h99, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge clk);
        checkOutput("sat_cnt", 32'(sStall), 32'hF);
        checkOutput("sat_hold", sData, 32'h99);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        applyStimulus(0, 0, 0, 8'h00, 32'h0, 1);
        @(negedge clk);
        checkOutput("sat_sticky", 32'(sStall), 32'hF);
        checkOutput("sat_empty", 32'(sVal), 32'd0);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
